bus_arbiter_rr: RTL



---
 rtl/bus_arbiter_rr_pkg.sv | 26 ++
 rtl/bus_arb_rr_pick.sv | 26 ++
 rtl/bus_arbiter_rr.sv | 84 ++++++++
 3 files changed

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the four-master bus: master count, owner encoding,
// active-low signal levels and the owner-to-grant decode.
package bus_arbiter_rr_pkg;

  localparam int BUS_MASTERS = 4;
  localparam int BUS_OWNER_W = 2;

  typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

  // Levels for the active-low request/grant/strobe lines.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  function automatic logic [BUS_MASTERS-1:0] bus_grant_decode(input bus_owner_t owner);
    logic [BUS_MASTERS-1:0] grnt_;
    grnt_ = {BUS_MASTERS{DISABLE_}};
    grnt_[owner] = ENABLE_;
    return grnt_;
  endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin candidate search: scans owner+1..owner+3 (mod 4) for the first
// active-high request. The current owner is never a candidate.
module bus_arb_rr_pick
  import bus_arbiter_rr_pkg::*;
(
  input  logic [BUS_MASTERS-1:0] req,
  input  bus_owner_t             owner,
  output bus_owner_t             next_owner,
  output logic                   found
);

  always_comb begin
    bus_owner_t cand;
    cand       = owner;
    next_owner = owner;
    found      = 1'b0;
    for (int i = 1; i < BUS_MASTERS; i++) begin
      cand = owner + bus_owner_t'(i);
      if (!found && req[cand]) begin
        next_owner = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the four-master shared bus: registered owner, no
// switch mid-transfer, and a tenure limit that forces rotation under contention.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       s_as_,
  input  logic       s_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       arb_switch
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [BUS_MASTERS-1:0] req;
  logic [BUS_MASTERS-1:0] owner_mask;
  logic [BUS_MASTERS-1:0] others_req;
  bus_owner_t             owner_q;
  bus_owner_t             next_owner;
  logic                   found;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [HOLD_W-1:0]      hold_cnt_inc;
  logic                   locked;
  logic                   owner_req;
  logic                   tenure_up;
  logic                   rearb;
  logic                   do_switch;

  assign req        = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_mask = {{(BUS_MASTERS-1){1'b0}}, 1'b1} << owner_q;
  assign others_req = req & ~owner_mask;
  assign owner_req  = |(req & owner_mask);

  // A started, not yet acknowledged transfer pins the bus to its owner.
  assign locked    = (s_as_ == ENABLE_) && (s_rdy_ == DISABLE_);
  assign tenure_up = (MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && (|others_req);
  assign rearb     = !locked && (!owner_req || tenure_up);
  assign do_switch = rearb && found;

  assign hold_cnt_inc = (owner_req && (hold_cnt != HOLD_MAX)) ? hold_cnt + HOLD_W'(1)
                                                              : hold_cnt;

  bus_arb_rr_pick u_pick (
    .req        (req),
    .owner      (owner_q),
    .next_owner (next_owner),
    .found      (found)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= BUS_OWNER_MASTER_0;
      hold_cnt   <= '0;
      arb_switch <= 1'b0;
    end else begin
      arb_switch <= do_switch;
      if (do_switch) begin
        owner_q  <= next_owner;
        hold_cnt <= '0;
      end else if (owner_req || locked) begin
        hold_cnt <= hold_cnt_inc;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  // Grants come only from the owner register, so req_ never reaches grnt_ combinationally.
  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = bus_grant_decode(owner_q);
  assign owner = owner_q;

endmodule
